// File: rtl/kcpsm_port_bank.sv
// kcpsm_port_bank: byte-wide KCPSM3 (PicoBlaze) port bank.
// - NUM_CH output words of WORD_BYTES bytes. Low bytes collect in a shadow
//   register, and a write to the top byte commits the whole word in one edge.
// - IN_CH input words. A byte-0 read snapshots the whole word, so multi-byte
//   reads stay coherent.
// - Per-input change flags are readable at port 8'hFF.
// Optional feature: define PORT_BANK_READBACK_EN to read committed output words
// back at port_id[7]=1. Without it, the output registers are write-only.
module kcpsm_port_bank #(
  parameter int NUM_CH     = 2,
  parameter int WORD_BYTES = 2,
  parameter int IN_CH      = 1
) (
  input  logic                           CLK1,
  input  logic                           arst,
  input  logic [7:0]                     port_id,
  input  logic                           write_strobe,
  input  logic                           read_strobe,
  input  logic [7:0]                     out_port,
  output logic [7:0]                     in_port,
  input  logic [IN_CH*WORD_BYTES*8-1:0]  in_words,
  output logic [NUM_CH*WORD_BYTES*8-1:0] out_words,
  output logic [NUM_CH-1:0]              commit
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int TOP   = WORD_BYTES - 1;
  localparam int RB_CH = (NUM_CH < 8) ? NUM_CH : 8;

  logic [3:0]        ch;
  logic [3:0]        b;
  logic              byte_ok;
  logic              top_hit;
  logic [NUM_CH-1:0] wr_sel;
  logic [IN_CH-1:0]  in_sel;
  logic [W-1:0]      shadow      [NUM_CH];
  logic [W-1:0]      commit_word [NUM_CH];
  logic [W-1:0]      snap        [IN_CH];
  logic [W-1:0]      prev        [IN_CH];
  logic [IN_CH-1:0]  flag;
  logic              armed;
  logic [7:0]        rd_data;

  assign ch = port_id[7:4];
  assign b  = port_id[3:0];

  // Address decode: the channel selects come from port_id[7:4], and the byte is checked against the word size.
  always_comb begin
    wr_sel  = '0;
    in_sel  = '0;
    byte_ok = ({1'b0, b} < 5'(WORD_BYTES));
    top_hit = (b == 4'(TOP));
    for (int i = 0; i < NUM_CH; i++) wr_sel[i] = (ch == 4'(i));
    for (int i = 0; i < IN_CH; i++)  in_sel[i] = (ch == 4'(i));
  end

  // Candidate word for a commit: the held low bytes with the incoming top byte on top.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      commit_word[i]                = shadow[i];
      commit_word[i][TOP*8 +: 8]    = out_port;
    end
  end

  // Output path: low-byte writes fill the shadow, and a top-byte write publishes the word and pulses commit.
  always_ff @(posedge CLK1) begin
    if (arst) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      out_words <= '0;
      commit    <= '0;
    end else begin
      commit <= '0;
      if (write_strobe && byte_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_sel[i]) begin
            if (top_hit) begin
              out_words[i*W +: W] <= commit_word[i];
              commit[i]           <= 1'b1;
            end else begin
              for (int j = 0; j < TOP; j++) begin
                if (b == 4'(j)) shadow[i][j*8 +: 8] <= out_port;
              end
            end
          end
        end
      end
    end
  end

  // Input path: snapshot on a byte-0 read, and track changes against the previous cycle's sample (set beats clear).
  always_ff @(posedge CLK1) begin
    if (arst) begin
      for (int i = 0; i < IN_CH; i++) begin
        snap[i] <= '0;
        prev[i] <= '0;
      end
      flag  <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      for (int i = 0; i < IN_CH; i++) begin
        prev[i] <= in_words[i*W +: W];
        if (read_strobe && in_sel[i] && (b == 4'd0)) begin
          snap[i] <= in_words[i*W +: W];
          flag[i] <= armed && (in_words[i*W +: W] != prev[i]);
        end else begin
          flag[i] <= flag[i] || (armed && (in_words[i*W +: W] != prev[i]));
        end
      end
    end
  end

  // Read mux: status at 8'hFF, snapshot bytes for input channels, optional committed-word readback, else zero.
  always_comb begin
    rd_data = 8'h00;
    if (port_id == 8'hFF) begin
      rd_data = 8'(flag);
    end else if (byte_ok) begin
      for (int i = 0; i < IN_CH; i++) begin
        for (int j = 0; j < WORD_BYTES; j++) begin
          if (in_sel[i] && (b == 4'(j))) rd_data = snap[i][j*8 +: 8];
        end
      end
`ifdef PORT_BANK_READBACK_EN
      for (int i = 0; i < RB_CH; i++) begin
        for (int j = 0; j < WORD_BYTES; j++) begin
          if (port_id[7] && (port_id[6:4] == 3'(i)) && (b == 4'(j)))
            rd_data = out_words[i*W + j*8 +: 8];
        end
      end
`endif
    end
  end

  // Registered read port; KCPSM3 holds port_id for two cycles, so the data is ready at its sample point.
  always_ff @(posedge CLK1) begin
    if (arst) in_port <= 8'h00;
    else      in_port <= rd_data;
  end

endmodule

// File: tb/tb_kcpsm_port_bank.sv
// Directed testbench for kcpsm_port_bank with the default parameters
// (2 output words, 2 bytes per word, 1 input word).
module tb_kcpsm_port_bank;

  logic        CLK1 = 1'b0;
  logic        arst;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic [15:0] in_words;
  logic [31:0] out_words;
  logic [1:0]  commit;

  int total = 0;
  int bad   = 0;

  kcpsm_port_bank #(.NUM_CH(2), .WORD_BYTES(2), .IN_CH(1)) dut (
    .CLK1(CLK1), .arst(arst), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .in_words(in_words), .out_words(out_words), .commit(commit)
  );

  always #5 CLK1 = ~CLK1;

  // Advance one clock and settle just past the edge before driving or sampling.
  task automatic tick;
    @(posedge CLK1);
    #1;
  endtask

  task automatic test_reset;
    arst = 1'b1; in_words = 16'hA55A;
    for (int i = 0; i < 2; i++) begin
      port_id = 8'($urandom_range(0, 255)); out_port = 8'($urandom_range(0, 255));
      write_strobe = 1'b1; read_strobe = 1'($urandom_range(0, 1));
      tick();
    end
    total++; if (out_words !== 32'h0) begin bad++; $display("[TB] FAIL reset_out_words: got %h expected %h", out_words, 32'h0); end
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL reset_commit: got %b expected %b", commit, 2'b00); end
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL reset_in_port: got %h expected %h", in_port, 8'h00); end
    write_strobe = 1'b0; read_strobe = 1'b0; port_id = 8'hFF; arst = 1'b0;
    tick();
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL post_reset_commit: got %b expected %b", commit, 2'b00); end
    tick(); tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL post_reset_flags: got %h expected %h", in_port, 8'h00); end
  endtask

  task automatic test_commit;
    port_id = 8'h00; out_port = 8'h34; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'h0) begin bad++; $display("[TB] FAIL low_byte_no_update: got %h expected %h", out_words, 32'h0); end
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL low_byte_no_commit: got %b expected %b", commit, 2'b00); end
    port_id = 8'h01; out_port = 8'h12; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'h0000_1234) begin bad++; $display("[TB] FAIL top_byte_commit: got %h expected %h", out_words, 32'h0000_1234); end
    total++; if (commit !== 2'b01) begin bad++; $display("[TB] FAIL commit_pulse: got %b expected %b", commit, 2'b01); end
    tick();
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL commit_single: got %b expected %b", commit, 2'b00); end
  endtask

  task automatic test_isolation;
    port_id = 8'h11; out_port = 8'hAB; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'hAB00_1234) begin bad++; $display("[TB] FAIL ch1_commit: got %h expected %h", out_words, 32'hAB00_1234); end
    total++; if (commit !== 2'b10) begin bad++; $display("[TB] FAIL ch1_pulse: got %b expected %b", commit, 2'b10); end
    port_id = 8'h22; out_port = 8'h5C; write_strobe = 1'b1; tick();
    port_id = 8'h12; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'hAB00_1234) begin bad++; $display("[TB] FAIL illegal_write: got %h expected %h", out_words, 32'hAB00_1234); end
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL illegal_commit: got %b expected %b", commit, 2'b00); end
  endtask

  task automatic test_readback;
    logic [7:0] exp0;
    logic [7:0] exp1;
`ifdef PORT_BANK_READBACK_EN
    exp0 = 8'h12; exp1 = 8'hAB;
`else
    exp0 = 8'h00; exp1 = 8'h00;
`endif
    port_id = 8'h81; tick(); tick();
    total++; if (in_port !== exp0) begin bad++; $display("[TB] FAIL readback_81: got %h expected %h", in_port, exp0); end
    port_id = 8'h91; tick(); tick();
    total++; if (in_port !== exp1) begin bad++; $display("[TB] FAIL readback_91: got %h expected %h", in_port, exp1); end
    port_id = 8'hA0; tick(); tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL readback_bad_ch: got %h expected %h", in_port, 8'h00); end
  endtask

  task automatic test_recommit;
    port_id = 8'h01; out_port = 8'h56; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'hAB00_5634) begin bad++; $display("[TB] FAIL recommit_shadow: got %h expected %h", out_words, 32'hAB00_5634); end
  endtask

  task automatic test_snapshot;
    in_words = 16'h00FF; port_id = 8'h00; tick();
    read_strobe = 1'b1; tick(); read_strobe = 1'b0;
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL snap_strobe_cycle: got %h expected %h", in_port, 8'h00); end
    in_words = 16'h0100; tick();
    total++; if (in_port !== 8'hFF) begin bad++; $display("[TB] FAIL snap_byte0: got %h expected %h", in_port, 8'hFF); end
    port_id = 8'h01; tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL snap_coherent_byte1: got %h expected %h", in_port, 8'h00); end
    port_id = 8'h02; tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL snap_bad_byte: got %h expected %h", in_port, 8'h00); end
  endtask

  task automatic test_flags;
    port_id = 8'h00; read_strobe = 1'b1; tick(); read_strobe = 1'b0;
    port_id = 8'hFF; tick(); tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL flag_cleared: got %h expected %h", in_port, 8'h00); end
    in_words = 16'h0200; tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL flag_latency_1: got %h expected %h", in_port, 8'h00); end
    tick();
    total++; if (in_port !== 8'h01) begin bad++; $display("[TB] FAIL flag_latency_2: got %h expected %h", in_port, 8'h01); end
    port_id = 8'h00; read_strobe = 1'b1; tick(); read_strobe = 1'b0;
    port_id = 8'hFF; tick(); tick();
    total++; if (in_port !== 8'h00) begin bad++; $display("[TB] FAIL flag_read_clear: got %h expected %h", in_port, 8'h00); end
    in_words = 16'h0300; port_id = 8'h00; read_strobe = 1'b1; tick(); read_strobe = 1'b0;
    port_id = 8'hFF; tick(); tick();
    total++; if (in_port !== 8'h01) begin bad++; $display("[TB] FAIL flag_set_wins: got %h expected %h", in_port, 8'h01); end
  endtask

  task automatic test_both_strobes;
    in_words = 16'h0400; port_id = 8'h00; out_port = 8'h77;
    write_strobe = 1'b1; read_strobe = 1'b1; tick();
    read_strobe = 1'b0;
    port_id = 8'h01; out_port = 8'h99; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'hAB00_9977) begin bad++; $display("[TB] FAIL both_write: got %h expected %h", out_words, 32'hAB00_9977); end
    total++; if (commit !== 2'b01) begin bad++; $display("[TB] FAIL both_commit: got %b expected %b", commit, 2'b01); end
    tick();
    total++; if (in_port !== 8'h04) begin bad++; $display("[TB] FAIL both_snapshot: got %h expected %h", in_port, 8'h04); end
  endtask

  task automatic test_mid_reset;
    port_id = 8'h00; out_port = 8'hEE; write_strobe = 1'b1; tick();
    arst = 1'b1; port_id = 8'h01; out_port = 8'h11; tick();
    total++; if (out_words !== 32'h0) begin bad++; $display("[TB] FAIL mid_reset_out: got %h expected %h", out_words, 32'h0); end
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL mid_reset_commit: got %b expected %b", commit, 2'b00); end
    arst = 1'b0; write_strobe = 1'b0; port_id = 8'hFF; tick();
    total++; if (commit !== 2'b00) begin bad++; $display("[TB] FAIL after_reset_commit: got %b expected %b", commit, 2'b00); end
    port_id = 8'h01; out_port = 8'h22; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    total++; if (out_words !== 32'h0000_2200) begin bad++; $display("[TB] FAIL shadow_discarded: got %h expected %h", out_words, 32'h0000_2200); end
  endtask

  initial begin
    arst = 1'b1; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = 8'h00; in_words = 16'h0000;
    test_reset();
    test_commit();
    test_isolation();
    test_readback();
    test_recommit();
    test_snapshot();
    test_flags();
    test_both_strobes();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kcpsm_port_bank.md
# kcpsm_port_bank

Parametrised byte-wide I/O port bank between the KCPSM3 (PicoBlaze) port bus and multi-byte datapath words. It generalises the two-byte output latch to NUM_CH output words of WORD_BYTES bytes each and adds tear-free commit, coherent multi-byte input snapshots and per-channel change flags. Its outputs feed bin2bcd/display-style consumers; its inputs come from counters and switches.

## Interface
Parameters:
- NUM_CH, 2: number of output words; 1..16.
- WORD_BYTES, 2: bytes per word, in and out; 1..16.
- IN_CH, 1: number of input words; 1..8.

Ports:
- CLK1  in  1  system clock; all logic on its rising edge.
- arst  in  1  reset, synchronous, active-high.
- port_id  in  8  KCPSM3 port address.
- write_strobe  in  1  KCPSM3 write qualifier.
- read_strobe  in  1  KCPSM3 read qualifier.
- out_port  in  8  KCPSM3 write data.
- in_port  out  8  KCPSM3 read data, registered.
- in_words  in  IN_CH*WORD_BYTES*8  input words; channel i at [i*W+:W], W=8*WORD_BYTES.
- out_words  out  NUM_CH*WORD_BYTES*8  committed output words, same packing.
- commit  out  NUM_CH  one-cycle pulse per channel when its word updates.

## Operation
- Address fields: ch = port_id[7:4], b = port_id[3:0]. Byte 0 is the LSB.
- Write, write_strobe=1, ch<NUM_CH, b<WORD_BYTES:
  - b < WORD_BYTES-1: byte stored in channel shadow[ch][b]; out_words unchanged.
  - b = WORD_BYTES-1 (top byte): out_words[ch] <= {out_port, shadow[ch][WORD_BYTES-2:0]} in one edge; commit[ch]=1 next cycle.
  - WORD_BYTES=1: every write commits directly.
  - Any other address: write ignored, nothing changes.
- Shadow bytes persist after commit; rewriting only the top byte recommits with the old low bytes.
- Read decode, evaluated every cycle from port_id:
  - port_id=8'hFF: in_port = {0.., flag[IN_CH-1:0]}, unused bits 0.
  - ch<IN_CH, b<WORD_BYTES: in_port = snap[ch][b].
  - Otherwise in_port = 8'h00.
- Snapshot: read_strobe=1 at ch<IN_CH, b=0 loads snap[ch] <= in_words[ch] (whole word) and clears flag[ch]. Reads of b>0 return the snapshot, never live data, so multi-byte reads are coherent. Software reads byte 0 first.
- Change flags: per input channel register prev[ch] sampled every cycle. flag[ch] sets when in_words[ch] != prev[ch]. Set and clear on the same edge: set wins.
- Reset state:
  - out_words, shadow, snap, prev and flag all 0.
  - commit = 0, in_port = 8'h00.
  - First post-reset cycle: prev captures in_words without setting flags.
- Reset mid-operation: a partial shadow update is discarded. No commit pulse is issued in the reset cycle or the cycle after.

## Timing
- Write to out_words: 1 cycle; visible the edge after the write_strobe cycle. commit is aligned with the new value.
- port_id to in_port: 1 cycle, registered. KCPSM3 holds port_id for 2 cycles, so data is valid at its sample point.
- Snapshot read: in_port for b=0 shows pre-snapshot data in the strobe cycle. It shows fresh snap data from the next cycle onward. Software therefore reads byte 0 twice or uses b>0 reads after the first.
- Flag latency: an input change is visible on the status port 2 cycles after it occurs (prev compare, then in_port register).
- write_strobe and read_strobe together: both actions are performed independently.

## Configuration
- PORT_BANK_READBACK_EN:
  - Defined: reads with port_id[7]=1, ch'=port_id[6:4] < NUM_CH and b<WORD_BYTES return committed out_words[ch'][b]. Input space then shrinks to ch<8 with port_id[7]=0; 8'hFF remains status.
  - Undefined: output registers are write-only, and addresses with port_id[7]=1 other than 8'hFF read 8'h00.

## Test plan
- Reset: assert arst 2 cycles with random bus activity -> out_words=0, commit=0, in_port=8'h00, flags=0.
- Tear-free commit (defaults): write 8'h34 to 8'h00; out_words[0] stays 0 with no commit. Write 8'h12 to 8'h01 -> out_words[0]=16'h1234 next cycle, commit[0] pulses once.
- Channel isolation and illegal address: write 8'hAB to 8'h11 -> out_words[1]=16'hAB00, channel 0 unchanged. Write to 8'h22 -> no change anywhere.
- Coherent snapshot: in_words=16'h00FF, read 8'h00 (snapshot), change in_words to 16'h0100, then read 8'h01 -> in_port=8'h00, not 8'h01.
- Flags: change in_words -> status bit0=1 after 2 cycles. Read 8'h00 -> bit0=0. Change input in the same cycle as the clearing read -> bit0 stays 1.
- Readback (PORT_BANK_READBACK_EN defined): after the commit of 16'h1234, read 8'h81 -> 8'h12. Macro undefined -> 8'h00.
